x87_issue_ctrl: RTL and testbench
=================================

// Module: x87_issue_ctrl
// PURPOSE
//   Sequences one x87 instruction at a time into x87_top. Accepts a request from the
//   pipeline (valid/ready), holds opcode/operands stable, pulses fpu_start, waits for
//   fpu_done, captures writeback and memory-store results, hands the store to the memory
//   write port (valid/ready), then returns a completion response. Optional hang watchdog.
// PARAMETERS
//   TIMEOUT_CYCLES  255  WAIT cycles before forced abort (watchdog build only); 1..2^CNT_W-1
//   CNT_W           8    watchdog counter width
// PORTS
//   clk              in   1   clock
//   rst_n            in   1   async active-low reset
//   req_valid        in   1   request present
//   req_ready        out  1   request accepted when valid&ready
//   req_op1/req_op2  in   8   opcode byte / ModRM byte
//   req_op2_valid    in   1   op2 meaningful
//   req_mem32        in   32  memory operand (32-bit forms)
//   req_mem64        in   64  memory operand (64-bit forms)
//   fpu_start        out  1   one-cycle start pulse to x87_top
//   fpu_op1/fpu_op2  out  8   held opcode/ModRM
//   fpu_op2_valid    out  1   held op2 qualifier
//   fpu_mem_rdata32  out  32  held memory operand
//   fpu_mem_rdata64  out  64  held memory operand
//   fpu_busy         in   1   x87_top busy (informational)
//   fpu_done         in   1   x87_top completion
//   fpu_wb_valid     in   1   writeback present;  fpu_wb_kind in 3, fpu_wb_value in 16
//   fpu_memstore_valid in 1   store present; fpu_memstore_size in 2, fpu_memstore_data64 in 64
//   st_valid         out  1   store to memory port
//   st_ready         in   1   memory port accepts store
//   st_size          out  2   captured store size
//   st_data          out  64  captured store data
//   rsp_valid        out  1   completion present
//   rsp_ready        in   1   completion consumed
//   rsp_wb_valid     out  1   completion carries writeback
//   rsp_wb_kind      out  3   captured wb kind
//   rsp_wb_value     out  16  captured wb value
//   rsp_timeout      out  1   completion is a watchdog abort
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; every output 0 (req_ready also 0 while in reset).
//   - States: IDLE -> ISSUE -> WAIT -> [STORE] -> RESP -> IDLE.
//   - IDLE: req_ready=1. On req_valid: latch op1/op2/op2_valid/mem32/mem64 into fpu_* regs,
//     clear captured wb/store/timeout flags, counter=0 -> ISSUE. fpu_done in IDLE ignored.
//   - ISSUE: fpu_start=1 for exactly this cycle -> WAIT. fpu_* operands held from latch
//     until next accept (never change while not IDLE).
//   - WAIT: each cycle, fpu_wb_valid=1 captures kind/value and sets sticky rsp_wb_valid;
//     fpu_memstore_valid=1 captures size/data and sets store-pending. Capture also occurs
//     in the same cycle as fpu_done. On fpu_done: store-pending -> STORE, else -> RESP.
//     Later captures in same WAIT overwrite earlier ones.
//   - STORE: st_valid=1, st_size/st_data stable until st_ready; on st_valid&st_ready -> RESP.
//   - RESP: rsp_valid=1, rsp_* stable until rsp_ready; on handshake -> IDLE. Earliest next
//     accept is the cycle after the response handshake (no overlap).
//   - Min latency accept->rsp_valid: 4 cycles given x87_top registered outputs (done seen
//     2 cycles after start).
//   - Reset mid-operation: instantly IDLE, any pending store/response dropped, no st_valid.
// CONFIGURATION
//   X87_ISSUE_TIMEOUT_EN defined: counter increments each WAIT cycle without fpu_done; when
//     counter reaches TIMEOUT_CYCLES -> RESP with rsp_timeout=1, rsp_wb_valid=0, captured
//     store discarded (never issued). fpu_done on the timeout cycle wins (normal path).
//   Not defined: no counter, WAIT waits indefinitely, rsp_timeout tied 0.
// TESTING
//   1 Reset: rst_n=0 mid-WAIT -> all outputs 0, state IDLE, req_ready=1 after release.
//   2 FLD-type: req D9/C0 valid, FPU wb_valid kind=1 value=16'h0003 with done -> one
//     fpu_start pulse, rsp_valid with rsp_wb_kind=1, rsp_wb_value=0003, rsp_timeout=0.
//   3 FSTP m64: memstore size=2 data=64'h4000_0000_0000_0000 + done, st_ready held 0 for
//     3 cycles -> st_valid/st_data stable 3 cycles, rsp_valid only after st handshake.
//   4 Backpressure: rsp_ready=0 for 5 cycles while req_valid=1 -> req_ready stays 0,
//     rsp_* stable, new req accepted the cycle after rsp handshake; fpu_op1 unchanged till then.
//   5 Watchdog (X87_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES=8): no fpu_done -> rsp_timeout=1
//     after 8 WAIT cycles, no st_valid; without macro, rsp_valid never rises.
//   6 Spurious fpu_done in IDLE -> no state change, no rsp_valid.

Source files
------------

// File: rtl/x87_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : x87_issue_ctrl                                                    |
// | Issues one x87 instruction at a time to x87_top. It captures writeback and |
// | store results, drives the memory store port, then returns a response.      |
// | Define X87_ISSUE_TIMEOUT_EN to build in the WAIT-state hang watchdog.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module x87_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op1,
    input  logic [7:0]  req_op2,
    input  logic        req_op2_valid,
    input  logic [31:0] req_mem32,
    input  logic [63:0] req_mem64,
    output logic        fpu_start,
    output logic [7:0]  fpu_op1,
    output logic [7:0]  fpu_op2,
    output logic        fpu_op2_valid,
    output logic [31:0] fpu_mem_rdata32,
    output logic [63:0] fpu_mem_rdata64,
    input  logic        fpu_busy,
    input  logic        fpu_done,
    input  logic        fpu_wb_valid,
    input  logic [2:0]  fpu_wb_kind,
    input  logic [15:0] fpu_wb_value,
    input  logic        fpu_memstore_valid,
    input  logic [1:0]  fpu_memstore_size,
    input  logic [63:0] fpu_memstore_data64,
    output logic        st_valid,
    input  logic        st_ready,
    output logic [1:0]  st_size,
    output logic [63:0] st_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wb_valid,
    output logic [2:0]  rsp_wb_kind,
    output logic [15:0] rsp_wb_value,
    output logic        rsp_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t r_state;
    logic   r_st_pend;

`ifdef X87_ISSUE_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             w_expire;

    // The counter is about to reach TIMEOUT_CYCLES on this WAIT cycle.
    assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    logic w_unused;
    assign w_unused = &{1'b0, fpu_busy};
`else
    logic w_unused;
    assign w_unused    = &{1'b0, fpu_busy, CNT_W'(TIMEOUT_CYCLES)};
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_st_pend       <= 1'b0;
            req_ready       <= 1'b0;
            fpu_start       <= 1'b0;
            fpu_op1         <= '0;
            fpu_op2         <= '0;
            fpu_op2_valid   <= 1'b0;
            fpu_mem_rdata32 <= '0;
            fpu_mem_rdata64 <= '0;
            st_valid        <= 1'b0;
            st_size         <= '0;
            st_data         <= '0;
            rsp_valid       <= 1'b0;
            rsp_wb_valid    <= 1'b0;
            rsp_wb_kind     <= '0;
            rsp_wb_value    <= '0;
`ifdef X87_ISSUE_TIMEOUT_EN
            rsp_timeout     <= 1'b0;
            r_cnt           <= '0;
`endif
        end else begin
            fpu_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        fpu_op1         <= req_op1;
                        fpu_op2         <= req_op2;
                        fpu_op2_valid   <= req_op2_valid;
                        fpu_mem_rdata32 <= req_mem32;
                        fpu_mem_rdata64 <= req_mem64;
                        rsp_wb_valid    <= 1'b0;
                        r_st_pend       <= 1'b0;
`ifdef X87_ISSUE_TIMEOUT_EN
                        rsp_timeout     <= 1'b0;
                        r_cnt           <= '0;
`endif
                        req_ready       <= 1'b0;
                        fpu_start       <= 1'b1;
                        r_state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fpu_wb_valid) begin
                        rsp_wb_kind  <= fpu_wb_kind;
                        rsp_wb_value <= fpu_wb_value;
                        rsp_wb_valid <= 1'b1;
                    end
                    if (fpu_memstore_valid) begin
                        st_size   <= fpu_memstore_size;
                        st_data   <= fpu_memstore_data64;
                        r_st_pend <= 1'b1;
                    end
                    // A store captured on the done cycle itself still counts.
                    if (fpu_done) begin
                        if (r_st_pend || fpu_memstore_valid) begin
                            st_valid <= 1'b1;
                            r_state  <= S_STORE;
                        end else begin
                            rsp_valid <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end
`ifdef X87_ISSUE_TIMEOUT_EN
                    else if (w_expire) begin
                        rsp_valid    <= 1'b1;
                        rsp_wb_valid <= 1'b0;
                        rsp_timeout  <= 1'b1;
                        r_st_pend    <= 1'b0;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_STORE: begin
                    if (st_ready) begin
                        st_valid  <= 1'b0;
                        r_st_pend <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_x87_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_x87_issue_ctrl                                                 |
// | Self-checking bench for x87_issue_ctrl: directed table, backpressure,      |
// | reset and watchdog sequences, plus randomized transactions.                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_x87_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [7:0]  req_op1 = '0, req_op2 = '0;
    logic        req_op2_valid = 1'b0;
    logic [31:0] req_mem32 = '0;
    logic [63:0] req_mem64 = '0;
    logic        fpu_start;
    logic [7:0]  fpu_op1, fpu_op2;
    logic        fpu_op2_valid;
    logic [31:0] fpu_mem_rdata32;
    logic [63:0] fpu_mem_rdata64;
    logic        fpu_busy = 1'b0, fpu_done = 1'b0, fpu_wb_valid = 1'b0;
    logic [2:0]  fpu_wb_kind = '0;
    logic [15:0] fpu_wb_value = '0;
    logic        fpu_memstore_valid = 1'b0;
    logic [1:0]  fpu_memstore_size = '0;
    logic [63:0] fpu_memstore_data64 = '0;
    logic        st_valid, st_ready = 1'b0;
    logic [1:0]  st_size;
    logic [63:0] st_data;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic        rsp_wb_valid;
    logic [2:0]  rsp_wb_kind;
    logic [15:0] rsp_wb_value;
    logic        rsp_timeout;

    int n_checks = 0;
    int n_errors = 0;

    x87_issue_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_op2_valid(req_op2_valid),
        .req_mem32(req_mem32), .req_mem64(req_mem64),
        .fpu_start(fpu_start), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2),
        .fpu_op2_valid(fpu_op2_valid), .fpu_mem_rdata32(fpu_mem_rdata32),
        .fpu_mem_rdata64(fpu_mem_rdata64), .fpu_busy(fpu_busy), .fpu_done(fpu_done),
        .fpu_wb_valid(fpu_wb_valid), .fpu_wb_kind(fpu_wb_kind), .fpu_wb_value(fpu_wb_value),
        .fpu_memstore_valid(fpu_memstore_valid), .fpu_memstore_size(fpu_memstore_size),
        .fpu_memstore_data64(fpu_memstore_data64),
        .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size), .st_data(st_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wb_valid(rsp_wb_valid),
        .rsp_wb_kind(rsp_wb_kind), .rsp_wb_value(rsp_wb_value), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // Per-WAIT-cycle results are base + cycle index; the last capture must win.
    typedef struct {
        logic [7:0]  op1, op2;
        logic        op2v;
        logic [31:0] m32;
        logic [63:0] m64;
        int          wait_n, st_stall, rsp_stall;
        logic [7:0]  wb_mask, ms_mask;
        logic [2:0]  kind;
        logic [15:0] val;
        logic [1:0]  size;
        logic [63:0] data;
        logic        e_wbv, e_st;
        logic [2:0]  e_kind;
        logic [15:0] e_val;
        logic [1:0]  e_size;
        logic [63:0] e_data;
    } txn_t;

    txn_t tbl[6];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        r.e_wbv = 1'b0; r.e_st = 1'b0;
        r.e_kind = '0; r.e_val = '0; r.e_size = '0; r.e_data = '0;
        for (int i = 0; i < t.wait_n; i++) begin
            if (t.wb_mask[i]) begin
                r.e_wbv = 1'b1; r.e_kind = t.kind + 3'(i); r.e_val = t.val + 16'(i);
            end
            if (t.ms_mask[i]) begin
                r.e_st = 1'b1; r.e_size = t.size + 2'(i); r.e_data = t.data + 64'(i);
            end
        end
        return r;
    endfunction

    task automatic run_txn(input txn_t t, input bit bp);
        req_valid = 1'b1; req_op1 = t.op1; req_op2 = t.op2; req_op2_valid = t.op2v;
        req_mem32 = t.m32; req_mem64 = t.m64;
        chk("req_ready_idle", 96'(req_ready), 96'(1));
        @(negedge clk);
        req_valid = 1'b0;
        chk("start_pulse", 96'(fpu_start), 96'(1));
        chk("req_ready_busy", 96'(req_ready), 96'(0));
        chk("op_latch", {fpu_op1, fpu_op2, fpu_op2_valid, fpu_mem_rdata32},
            {t.op1, t.op2, t.op2v, t.m32});
        chk("m64_latch", 96'(fpu_mem_rdata64), 96'(t.m64));
        chk("flags_clr", {rsp_wb_valid, rsp_timeout}, 96'(0));
        @(negedge clk);
        for (int i = 0; i < t.wait_n; i++) begin
            chk("wait_quiet", {fpu_start, st_valid, rsp_valid}, 96'(0));
            fpu_wb_valid = t.wb_mask[i]; fpu_wb_kind = t.kind + 3'(i);
            fpu_wb_value = t.val + 16'(i);
            fpu_memstore_valid = t.ms_mask[i]; fpu_memstore_size = t.size + 2'(i);
            fpu_memstore_data64 = t.data + 64'(i);
            fpu_done = (i == t.wait_n - 1);
            @(negedge clk);
        end
        fpu_done = 1'b0; fpu_wb_valid = 1'b0; fpu_memstore_valid = 1'b0;
        if (t.e_st) begin
            for (int s = 0; s <= t.st_stall; s++) begin
                chk("st_valid", 96'(st_valid), 96'(1));
                chk("st_payload", {st_size, st_data}, {t.e_size, t.e_data});
                chk("st_no_rsp", 96'(rsp_valid), 96'(0));
                st_ready = (s == t.st_stall);
                @(negedge clk);
            end
            st_ready = 1'b0;
        end
        chk("no_st", 96'(st_valid), 96'(0));
        for (int r = 0; r <= t.rsp_stall; r++) begin
            chk("rsp_valid", 96'(rsp_valid), 96'(1));
            chk("rsp_wb_valid", 96'(rsp_wb_valid), 96'(t.e_wbv));
            if (t.e_wbv) chk("rsp_wb", {rsp_wb_kind, rsp_wb_value}, {t.e_kind, t.e_val});
            chk("rsp_timeout", 96'(rsp_timeout), 96'(0));
            chk("req_ready_resp", 96'(req_ready), 96'(0));
            chk("op_held", {fpu_op1, fpu_mem_rdata64}, {t.op1, t.m64});
            if (bp) begin req_valid = 1'b1; req_op1 = 8'hAA; end
            rsp_ready = (r == t.rsp_stall);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("rsp_drop", 96'(rsp_valid), 96'(0));
        chk("req_ready_back", 96'(req_ready), 96'(1));
        chk("op_unchanged", 96'(fpu_op1), 96'(t.op1));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ctrl", {req_ready, fpu_start, st_valid, rsp_valid, rsp_wb_valid, rsp_timeout},
            96'(0));
        chk("rst_ops", {fpu_op1, fpu_op2, fpu_op2_valid, fpu_mem_rdata32}, 96'(0));
        chk("rst_m64", 96'(fpu_mem_rdata64), 96'(0));
        chk("rst_st", {st_size, st_data}, 96'(0));
        chk("rst_wb", {rsp_wb_kind, rsp_wb_value}, 96'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_rst", 96'(req_ready), 96'(1));
    endtask

    task automatic start_hang_txn();
        req_valid = 1'b1; req_op1 = 8'hDD; req_op2 = 8'h18; req_op2_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        txn_t t, t2;
        bit   seen;

        tbl[0] = '{op1:8'hD9, op2:8'hC0, op2v:1'b1, m32:32'h0, m64:64'h0, wait_n:2,
                   st_stall:0, rsp_stall:0, wb_mask:8'b10, ms_mask:8'b0, kind:3'd0,
                   val:16'h0002, size:2'd0, data:64'h0, e_wbv:1'b1, e_st:1'b0,
                   e_kind:3'd1, e_val:16'h0003, e_size:2'd0, e_data:64'h0};
        tbl[1] = '{op1:8'hDD, op2:8'h18, op2v:1'b1, m32:32'h1111_2222, m64:64'h0, wait_n:1,
                   st_stall:3, rsp_stall:0, wb_mask:8'b0, ms_mask:8'b1, kind:3'd0,
                   val:16'h0, size:2'd2, data:64'h4000_0000_0000_0000, e_wbv:1'b0, e_st:1'b1,
                   e_kind:3'd0, e_val:16'h0, e_size:2'd2, e_data:64'h4000_0000_0000_0000};
        tbl[2] = '{op1:8'hD8, op2:8'hC1, op2v:1'b1, m32:32'h0, m64:64'h5, wait_n:4,
                   st_stall:0, rsp_stall:1, wb_mask:8'b0101, ms_mask:8'b0, kind:3'd2,
                   val:16'h1000, size:2'd0, data:64'h0, e_wbv:1'b1, e_st:1'b0,
                   e_kind:3'd4, e_val:16'h1002, e_size:2'd0, e_data:64'h0};
        tbl[3] = '{op1:8'hDC, op2:8'h00, op2v:1'b0, m32:32'hCAFE, m64:64'h9, wait_n:3,
                   st_stall:1, rsp_stall:0, wb_mask:8'b001, ms_mask:8'b110, kind:3'd5,
                   val:16'hABCD, size:2'd1, data:64'h1234, e_wbv:1'b1, e_st:1'b1,
                   e_kind:3'd5, e_val:16'hABCD, e_size:2'd3, e_data:64'h1236};
        tbl[4] = '{op1:8'hD9, op2:8'hE8, op2v:1'b0, m32:32'h0, m64:64'h0, wait_n:1,
                   st_stall:0, rsp_stall:0, wb_mask:8'b0, ms_mask:8'b0, kind:3'd0,
                   val:16'h0, size:2'd0, data:64'h0, e_wbv:1'b0, e_st:1'b0,
                   e_kind:3'd0, e_val:16'h0, e_size:2'd0, e_data:64'h0};
        tbl[5] = '{op1:8'hDF, op2:8'h38, op2v:1'b1, m32:32'h0, m64:64'h7777, wait_n:5,
                   st_stall:0, rsp_stall:2, wb_mask:8'b0, ms_mask:8'b00001, kind:3'd0,
                   val:16'h0, size:2'd0, data:64'hDEAD_BEEF_0000_0000, e_wbv:1'b0, e_st:1'b1,
                   e_kind:3'd0, e_val:16'h0, e_size:2'd0, e_data:64'hDEAD_BEEF_0000_0000};

        // Power-on reset.
        #1;
        chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_por", 96'(req_ready), 96'(1));

        for (int k = 0; k < 6; k++) run_txn(tbl[k], 1'b0);

        // Response backpressure with a waiting request.
        t = tbl[0]; t.rsp_stall = 5;
        run_txn(t, 1'b1);
        t2 = tbl[4]; t2.op1 = 8'hAA;
        run_txn(t2, 1'b0);

        // Spurious completion while idle.
        for (int k = 0; k < 3; k++) begin
            fpu_done = 1'b1; fpu_wb_valid = 1'b1; fpu_memstore_valid = 1'b1;
            @(negedge clk);
            chk("idle_spurious", {fpu_start, st_valid, rsp_valid, req_ready}, 96'(1));
        end
        fpu_done = 1'b0; fpu_wb_valid = 1'b0; fpu_memstore_valid = 1'b0;

        for (int k = 0; k < 40; k++) begin
            t.op1 = 8'($urandom); t.op2 = 8'($urandom); t.op2v = 1'($urandom);
            t.m32 = $urandom; t.m64 = {$urandom, $urandom};
            t.wait_n = $urandom_range(1, 6);
            t.st_stall = $urandom_range(0, 3); t.rsp_stall = $urandom_range(0, 3);
            t.wb_mask = 8'($urandom); t.ms_mask = 8'($urandom) & 8'($urandom);
            t.kind = 3'($urandom); t.val = 16'($urandom);
            t.size = 2'($urandom); t.data = {$urandom, $urandom};
            t = model(t);
            run_txn(t, 1'b0);
        end

        // Hung FPU: no fpu_done ever arrives.
        start_hang_txn();
`ifdef X87_ISSUE_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            chk("wd_wait", {rsp_valid, st_valid}, 96'(0));
            fpu_memstore_valid = (i == 0); fpu_wb_valid = (i == 1);
            @(negedge clk);
        end
        fpu_memstore_valid = 1'b0; fpu_wb_valid = 1'b0;
        chk("wd_rsp", {rsp_valid, rsp_timeout, rsp_wb_valid, st_valid}, 96'b1100);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("wd_done", {rsp_valid, st_valid, req_ready}, 96'b001);
`else
        seen = 1'b0;
        fpu_memstore_valid = 1'b1;
        @(negedge clk);
        fpu_memstore_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid || st_valid || rsp_timeout) seen = 1'b1;
            @(negedge clk);
        end
        chk("no_watchdog", 96'(seen), 96'(0));
        do_reset();
`endif

        // Reset while a store is pending in WAIT.
        start_hang_txn();
        fpu_memstore_valid = 1'b1; fpu_memstore_size = 2'd2;
        fpu_memstore_data64 = 64'h55;
        @(negedge clk);
        fpu_memstore_valid = 1'b0;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (st_valid || rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("no_store_after_rst", 96'(seen), 96'(0));
        run_txn(tbl[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
